cp0_timer_unit: RTL
===================

Name: cp0_timer_unit

Overview:
- Parametrised successor to the single Count/Compare timer inside the CP0 register file.
- Provides one free-running Count with a programmable prescaler and N_CMP independent Compare channels. Each channel has a sticky pending interrupt bit.
- Sits beside the CP0 register file and uses the same write/read addressing (reg number plus sel). Its interrupt vector feeds Cause.IP and the pipeline interrupt logic.

Parameters:
- N_CMP, 1, number of Compare channels (1..4); channel i is reg 11, sel i.
- COUNT_W, 32, Count/Compare width (16..32); reads and writes use data bits [COUNT_W-1:0], zero-extended on read.
- DIV, 1, prescaler ratio; Count advances once every DIV clk cycles (DIV >= 1; DIV=2 gives MIPS half-rate Count).

Ports:
- clk  in  1  clock
- rst  in  1  synchronous reset, active-high
- we_i  in  1  register write enable
- waddr_i  in  5  write register number
- wsel_i  in  3  write select
- data_i  in  32  write data
- raddr_i  in  5  read register number
- rsel_i  in  3  read select
- halt_i  in  1  freezes Count and prescaler (debug/stall)
- data_o  out  32  combinational read data
- count_o  out  COUNT_W  current Count
- timer_int_o  out  N_CMP  per-channel pending bits
- irq_o  out  1  OR of timer_int_o

Behaviour:
- Reset values: Count 0, prescaler 0, all Compare 0, all pending 0, irq_o 0, data_o 0.
- Prescaler pre_q counts 0..DIV-1. Tick when pre_q==DIV-1 and !halt_i; pre_q then wraps to 0. With DIV=1, every non-halted cycle is a tick. halt_i holds both pre_q and Count.
- Count increments by 1 on a tick, modulo 2^COUNT_W (all-ones wraps to 0).
- Count write (we_i, waddr_i=9, wsel_i=0): Count <= data_i[COUNT_W-1:0] and pre_q <= 0. The write beats a same-cycle increment.
- Compare write (we_i, waddr_i=11, wsel_i<N_CMP): cmp[wsel_i] <= data_i and pending[wsel_i] <= 0. If a match occurs in the same cycle, the clear wins.
- Writes with wsel_i >= N_CMP, or to any other register, are ignored.
- Match, channel i: cmp[i] != 0 and Count (registered value) == cmp[i]. The match sets pending[i] on the next edge.
  - A zero Compare disables the channel.
  - Pending is sticky until that channel's Compare is written. halt_i does not mask a match already present.
  - Matches are checked every cycle. With DIV>1 the equality holds for DIV cycles; this is harmless because pending is sticky.
- Latency: a Count value equal to Compare becomes visible on count_o at edge k; timer_int_o[i] rises at edge k+1; irq_o rises combinationally with it.
- Read (combinational, no side effects):
  - raddr_i=9, sel 0 returns Count.
  - raddr_i=11, sel<N_CMP returns cmp[sel].
  - All other addresses return 0.
  - A read and a write to the same register in the same cycle returns the old value.
- Reset mid-operation: every register returns to its reset value on the next edge. No pending state survives.

Optional Feature:
- Macro CP0_TIMER_PERIODIC_EN.
- Defined:
  - Each channel gets a period register per[i] at reg 22, sel i, with reset value 0.
  - On a match with per[i] != 0: pending[i] is set and cmp[i] <= cmp[i] + per[i] (mod 2^COUNT_W) on the same edge, giving periodic interrupts without software rewrite.
  - A Compare write in the same cycle overrides the reload.
  - per[i] reads back at reg 22.
- Undefined: no period registers. Reg 22 reads 0 and writes are ignored. Behaviour is identical to one-shot mode.

Decomposition:
- Shared CP0 defines package holds:
  - register numbers CP0_REG_COUNT (9), CP0_REG_COMPARE (11), CP0_REG_PERIOD (22);
  - WriteEnable, RstEnable and ZeroWord constants.
- One natural sub-module, cp0_timer_chan: holds cmp, pending and optional per for one channel; instantiated N_CMP times by generate.
- Prescaler and Count stay in the top level.

Test Plan:
- Reset, defaults (DIV=1): hold rst 3 cycles, release -> count_o reads 0,1,2 on successive edges; timer_int_o=0; read reg 11 sel 0 -> 0.
- Match (DIV=1): write Compare sel0=10 at count 2 -> count_o==10 at edge k, timer_int_o[0]=1 at k+1, irq_o=1; stays 1 through Count wrap; write Compare sel0=50 -> pending 0 next edge.
- Multi-channel (N_CMP=2, DIV=2): cmp0=4, cmp1=6 -> Count advances every 2 cycles; timer_int_o=01 then 11; write wsel=3 -> ignored, read reg 11 sel 3 = 0.
- Collisions: Count write 0x100 in the same cycle as a tick -> Count=0x100; Compare write in the match cycle -> pending stays 0; halt_i held 5 cycles -> count_o frozen.
- Wrap (COUNT_W=16): Count=0xFFFF, cmp=1 -> Count 0x0000 then 0x0001, pending set the following edge.
- Periodic (CP0_TIMER_PERIODIC_EN): cmp0=5, per0=5 -> pending set after Count 5, cmp0 reads 10; clear by writing cmp0=10 -> set again after Count 10, cmp0 reads 15.

Source files
------------

// File: rtl/cp0_timer_unit_pkg.sv
// rtl/cp0_timer_unit_pkg.sv - shared CP0 register numbers, constants and address decode for the timer unit
package cp0_timer_unit_pkg;

    localparam logic [4:0]  CP0_REG_COUNT   = 5'd9;
    localparam logic [4:0]  CP0_REG_COMPARE = 5'd11;
    localparam logic [4:0]  CP0_REG_PERIOD  = 5'd22;

    localparam logic        WriteEnable = 1'b1;
    localparam logic        RstEnable   = 1'b1;
    localparam logic [31:0] ZeroWord    = 32'h0000_0000;

    typedef enum logic [1:0] {
        REG_NONE,
        REG_COUNT,
        REG_COMPARE,
        REG_PERIOD
    } reg_kind_e;

    function automatic reg_kind_e decode_reg(input logic [4:0] addr);
        reg_kind_e kind;
        case (addr)
            CP0_REG_COUNT:   kind = REG_COUNT;
            CP0_REG_COMPARE: kind = REG_COMPARE;
            CP0_REG_PERIOD:  kind = REG_PERIOD;
            default:         kind = REG_NONE;
        endcase
        return kind;
    endfunction

endpackage

// File: rtl/cp0_timer_unit_chan.sv
// rtl/cp0_timer_unit_chan.sv - one Compare channel: cmp, sticky pending, per reload under CP0_TIMER_PERIODIC_EN
module cp0_timer_chan
    import cp0_timer_unit_pkg::*;
#(
    parameter int COUNT_W = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [COUNT_W-1:0] count,
    input  logic               cmp_we,
`ifdef CP0_TIMER_PERIODIC_EN
    input  logic               per_we,
    output logic [COUNT_W-1:0] per,
`endif
    input  logic [COUNT_W-1:0] wdata,
    output logic [COUNT_W-1:0] cmp,
    output logic               pending
);

    logic [COUNT_W-1:0] cmp_q;
    logic               pending_q;
    logic               match;

    // A zero Compare disables the channel.
    assign match = (cmp_q != '0) && (count == cmp_q);

`ifdef CP0_TIMER_PERIODIC_EN
    logic [COUNT_W-1:0] per_q;

    always_ff @(posedge clk) begin
        if (rst == RstEnable) begin
            per_q <= '0;
        end else if (per_we) begin
            per_q <= wdata;
        end
    end

    assign per = per_q;
`endif

    // A Compare write clears pending and overrides any same-cycle match or reload.
    always_ff @(posedge clk) begin
        if (rst == RstEnable) begin
            cmp_q     <= '0;
            pending_q <= 1'b0;
        end else if (cmp_we) begin
            cmp_q     <= wdata;
            pending_q <= 1'b0;
        end else if (match) begin
            pending_q <= 1'b1;
`ifdef CP0_TIMER_PERIODIC_EN
            if (per_q != '0) begin
                cmp_q <= cmp_q + per_q;
            end
`endif
        end
    end

    assign cmp     = cmp_q;
    assign pending = pending_q;

endmodule

// File: rtl/cp0_timer_unit.sv
// rtl/cp0_timer_unit.sv - CP0 Count with prescaler and N_CMP Compare channels; CP0_TIMER_PERIODIC_EN adds period regs
module cp0_timer_unit
    import cp0_timer_unit_pkg::*;
#(
    parameter int N_CMP   = 1,
    parameter int COUNT_W = 32,
    parameter int DIV     = 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               we_i,
    input  logic [4:0]         waddr_i,
    input  logic [2:0]         wsel_i,
    input  logic [31:0]        data_i,
    input  logic [4:0]         raddr_i,
    input  logic [2:0]         rsel_i,
    input  logic               halt_i,
    output logic [31:0]        data_o,
    output logic [COUNT_W-1:0] count_o,
    output logic [N_CMP-1:0]   timer_int_o,
    output logic               irq_o
);

    localparam int                PRE_W    = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [PRE_W-1:0]  PRE_LAST = PRE_W'(DIV - 1);

    logic [PRE_W-1:0]   pre_q;
    logic [COUNT_W-1:0] count_q;
    logic [COUNT_W-1:0] wdata;
    logic               tick;
    logic               count_we;
    reg_kind_e          wkind;
    reg_kind_e          rkind;

    logic [COUNT_W-1:0] cmp_q [N_CMP];
    logic [N_CMP-1:0]   pend;

    assign wdata    = data_i[COUNT_W-1:0];
    assign wkind    = decode_reg(waddr_i);
    assign rkind    = decode_reg(raddr_i);
    assign count_we = (we_i == WriteEnable) && (wkind == REG_COUNT) && (wsel_i == 3'd0);
    assign tick     = (pre_q == PRE_LAST) && !halt_i;

    generate
        if (COUNT_W < 32) begin : g_hi_bits
            logic unused_hi;
            assign unused_hi = ^data_i[31:COUNT_W];
        end
    endgenerate

    // A Count write restarts the prescaler and beats a same-cycle increment.
    always_ff @(posedge clk) begin
        if (rst == RstEnable) begin
            pre_q   <= '0;
            count_q <= '0;
        end else if (count_we) begin
            pre_q   <= '0;
            count_q <= wdata;
        end else if (!halt_i) begin
            if (tick) begin
                pre_q   <= '0;
                count_q <= count_q + COUNT_W'(1);
            end else begin
                pre_q   <= pre_q + PRE_W'(1);
            end
        end
    end

`ifdef CP0_TIMER_PERIODIC_EN
    logic [COUNT_W-1:0] per_q [N_CMP];
`endif

    generate
        for (genvar i = 0; i < N_CMP; i++) begin : g_chan
            logic cmp_we;
            assign cmp_we = (we_i == WriteEnable) && (wkind == REG_COMPARE) && (wsel_i == 3'(i));
`ifdef CP0_TIMER_PERIODIC_EN
            logic per_we;
            assign per_we = (we_i == WriteEnable) && (wkind == REG_PERIOD) && (wsel_i == 3'(i));
`endif

            cp0_timer_chan #(
                .COUNT_W (COUNT_W)
            ) u_chan (
                .clk     (clk),
                .rst     (rst),
                .count   (count_q),
                .cmp_we  (cmp_we),
`ifdef CP0_TIMER_PERIODIC_EN
                .per_we  (per_we),
                .per     (per_q[i]),
`endif
                .wdata   (wdata),
                .cmp     (cmp_q[i]),
                .pending (pend[i])
            );
        end
    endgenerate

    // Reads see the registered values, so a same-cycle write returns the old value.
    always_comb begin
        data_o = ZeroWord;
        case (rkind)
            REG_COUNT: begin
                if (rsel_i == 3'd0) data_o = 32'(count_q);
            end
            REG_COMPARE: begin
                for (int i = 0; i < N_CMP; i++) begin
                    if (rsel_i == 3'(i)) data_o = 32'(cmp_q[i]);
                end
            end
`ifdef CP0_TIMER_PERIODIC_EN
            REG_PERIOD: begin
                for (int i = 0; i < N_CMP; i++) begin
                    if (rsel_i == 3'(i)) data_o = 32'(per_q[i]);
                end
            end
`endif
            default: ;
        endcase
    end

    assign count_o     = count_q;
    assign timer_int_o = pend;
    assign irq_o       = |pend;

endmodule
